// File: rtl/pfd_tdc.sv
// pfd_tdc -- oversampled phase-frequency detector with time-to-digital output.
//
// Both clock inputs are synchronised into the clk domain and turned into
// rising-edge pulses. A three-state FSM (IDLE / UP / DOWN) counts clk cycles
// between the leading edge and the closing edge and reports the signed
// interval as a phase error for the ADPLL loop filter.
//
// Ports:
//   clk        sampling clock, everything on its rising edge
//   reset      asynchronous, active-high reset
//   ref_clk    reference clock (asynchronous to clk)
//   data       divided-DCO feedback clock (asynchronous to clk)
//   up         high while ref has led and the data edge is pending
//   down       high while data has led and the ref edge is pending
//   err        signed phase error, positive = ref leads; held between updates
//   err_valid  one-cycle strobe, err updated this cycle
//   slip       one-cycle strobe with err_valid, cycle slip detected
//   locked     lock indicator
module pfd_tdc #(
  parameter int ERR_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = 0,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_COUNT  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ref_clk,
  input  logic                    data,
  output logic                    up,
  output logic                    down,
  output logic signed [ERR_W-1:0] err,
  output logic                    err_valid,
  output logic                    slip,
  output logic                    locked
);

  localparam int CW = ERR_W - 1;
  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam int AW = $clog2(SYNC_STAGES + 2);

  localparam logic [CW-1:0]           CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0]           CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]           TOL      = CW'(LOCK_TOL);
  localparam logic [LW-1:0]           LOCK_MAX = LW'(LOCK_COUNT);
  localparam logic [AW-1:0]           ARM_LAST = AW'(SYNC_STAGES + 1);
  localparam logic signed [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers and rising-edge detectors. Channel 0 = ref, 1 = data.
  // ---------------------------------------------------------------------------
  logic [1:0]    pins;
  logic [1:0]    rise;
  logic [AW-1:0] arm_cnt_reg;
  logic          armed;

  assign pins = {data, ref_clk};

  // The synchronisers come out of reset cleared, so a level held high across
  // reset would look like a fresh edge once it propagates. Edge detection is
  // held off until the chain and the previous-value flop have both refilled.
  assign armed = (arm_cnt_reg == ARM_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_cnt_reg <= '0;
    end else if (!armed) begin
      arm_cnt_reg <= arm_cnt_reg + AW'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_in
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   prev_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync_reg <= '0;
          prev_reg <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], pins[gi]};
          prev_reg <= sync_reg[SYNC_STAGES-1];
        end
      end

      assign rise[gi] = armed & sync_reg[SYNC_STAGES-1] & ~prev_reg;
    end
  endgenerate

  logic re_ref;
  logic re_data;
  assign re_ref  = rise[0];
  assign re_data = rise[1];

  // ---------------------------------------------------------------------------
  // Measurement FSM
  // ---------------------------------------------------------------------------
  state_t                   state_reg, state_next;
  logic [CW-1:0]            cnt_reg, cnt_next;
  logic [CW-1:0]            cnt_inc;
  logic                     upd_next;
  logic                     slip_next;
  logic                     neg_next;
  logic [CW-1:0]            mag_next;
  logic signed [ERR_W-1:0]  mag_ext;
  logic signed [ERR_W-1:0]  lin_err;
  logic signed [ERR_W-1:0]  err_next;
  logic                     in_tol;
  logic [LW-1:0]            lock_cnt_reg;

  // Interval counter sticks at full scale instead of wrapping.
  assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    upd_next   = 1'b0;
    slip_next  = 1'b0;
    neg_next   = 1'b0;
    mag_next   = '0;

    case (state_reg)
      S_IDLE: begin
        if (re_ref && re_data) begin
          upd_next = 1'b1;              // coincident edges: zero error
        end else if (re_ref) begin
          state_next = S_UP;
          cnt_next   = CNT_ONE;
        end else if (re_data) begin
          state_next = S_DOWN;
          cnt_next   = CNT_ONE;
        end
      end

      S_UP: begin
        if (re_data) begin
          upd_next = 1'b1;
          mag_next = cnt_reg;
          if (re_ref) begin
            cnt_next = CNT_ONE;         // new ref edge opens the next interval
          end else begin
            state_next = S_IDLE;
          end
        end else if (re_ref) begin
          upd_next  = 1'b1;             // second ref edge before data: slip
          slip_next = 1'b1;
          mag_next  = CNT_MAX;
          cnt_next  = CNT_ONE;
        end else begin
          cnt_next = cnt_inc;
        end
      end

      S_DOWN: begin
        neg_next = 1'b1;
        if (re_ref) begin
          upd_next = 1'b1;
          mag_next = cnt_reg;
          if (re_data) begin
            cnt_next = CNT_ONE;
          end else begin
            state_next = S_IDLE;
          end
        end else if (re_data) begin
          upd_next  = 1'b1;
          slip_next = 1'b1;
          mag_next  = CNT_MAX;
          cnt_next  = CNT_ONE;
        end else begin
          cnt_next = cnt_inc;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    mag_ext = {1'b0, mag_next};
    lin_err = neg_next ? -mag_ext : mag_ext;

    // Bang-bang mode keeps only the sign; the lock test below still uses the
    // linear magnitude so tolerance means the same thing in both modes.
    if (MODE == 1) begin
      if (mag_next == '0) begin
        err_next = '0;
      end else begin
        err_next = neg_next ? -ERR_ONE : ERR_ONE;
      end
    end else begin
      err_next = lin_err;
    end

    in_tol = (mag_next <= TOL) && !slip_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      up           <= 1'b0;
      down         <= 1'b0;
      err          <= '0;
      err_valid    <= 1'b0;
      slip         <= 1'b0;
      lock_cnt_reg <= '0;
      locked       <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      // up/down are flopped copies of the next state, so they line up with
      // state_reg exactly and are glitch-free.
      up        <= (state_next == S_UP);
      down      <= (state_next == S_DOWN);
      err_valid <= upd_next;
      slip      <= slip_next;
      if (upd_next) begin
        err <= err_next;
        if (in_tol) begin
          if (lock_cnt_reg != LOCK_MAX) begin
            lock_cnt_reg <= lock_cnt_reg + LW'(1);
          end
        end else begin
          lock_cnt_reg <= '0;
        end
      end
      // One cycle behind lock_cnt: rises the cycle after the final good
      // measurement is reported, falls the cycle after a bad one.
      locked <= (lock_cnt_reg == LOCK_MAX);
    end
  end

endmodule

// File: tb/tb_pfd_tdc.sv
// tb_pfd_tdc -- scoreboard bench for pfd_tdc.
// dut0 runs in linear mode, dut1 in bang-bang mode. Stimulus pushes the
// expected err/slip (and, where fixed, the strobe cycle) into a queue; a
// negedge monitor per DUT pops and compares on every err_valid.
`timescale 1ns/1ps
module tb_pfd_tdc;

  localparam int ERR_W = 8;
  localparam int S     = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset0, ref0, data0, up0, down0, ev0, slip0, locked0;
  logic reset1, ref1, data1, up1, down1, ev1, slip1, locked1;
  logic signed [ERR_W-1:0] err0, err1;

  pfd_tdc #(.ERR_W(ERR_W), .SYNC_STAGES(S), .MODE(0), .LOCK_TOL(2), .LOCK_COUNT(16)) dut0 (
    .clk(clk), .reset(reset0), .ref_clk(ref0), .data(data0),
    .up(up0), .down(down0), .err(err0), .err_valid(ev0), .slip(slip0), .locked(locked0)
  );

  pfd_tdc #(.ERR_W(ERR_W), .SYNC_STAGES(S), .MODE(1), .LOCK_TOL(2), .LOCK_COUNT(16)) dut1 (
    .clk(clk), .reset(reset1), .ref_clk(ref1), .data(data1),
    .up(up1), .down(down1), .err(err1), .err_valid(ev1), .slip(slip1), .locked(locked1)
  );

  typedef struct {
    logic signed [ERR_W-1:0] err;
    logic                    slip;
    int                      cyc;   // expected strobe cycle, -1 = not checked
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int up_cnt0, down_cnt0, ev_cnt0;
  int up_cnt1, down_cnt1, ev_cnt1;
  int lockv[16] = '{1, -1, 2, -2, 0, 1, 2, -1, 0, -2, 1, 1, -1, 2, 0, -2};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic signed [63:0] got,
                     input logic signed [63:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin : mon0
    exp_t e;
    if (up0)   up_cnt0++;
    if (down0) down_cnt0++;
    if (up0 && down0) begin
      tests++; fails++;
      $display("FAIL dut0 up/down both high at cycle %0d", cyc);
    end
    if (ev0 === 1'b1) begin
      ev_cnt0++;
      if (q0.size() == 0) begin
        tests++; fails++;
        $display("FAIL dut0 unexpected err_valid at cycle %0d: got err %0d, expected no strobe", cyc, err0);
      end else begin
        e = q0.pop_front();
        chk("dut0 err", err0, e.err);
        chk("dut0 slip", slip0, e.slip);
        if (e.cyc >= 0) chk("dut0 strobe cycle", cyc, e.cyc);
      end
    end else if (slip0 === 1'b1) begin
      tests++; fails++;
      $display("FAIL dut0 slip without err_valid at cycle %0d: got 1, expected 0", cyc);
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (up1)   up_cnt1++;
    if (down1) down_cnt1++;
    if (ev1 === 1'b1) begin
      ev_cnt1++;
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL dut1 unexpected err_valid at cycle %0d: got err %0d, expected no strobe", cyc, err1);
      end else begin
        e = q1.pop_front();
        chk("dut1 err", err1, e.err);
        chk("dut1 slip", slip1, e.slip);
        if (e.cyc >= 0) chk("dut1 strobe cycle", cyc, e.cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // d > 0: ref leads by d cycles; d < 0: data leads; d = 0: same cycle.
  task automatic edges0(input int d);
    int   k;
    exp_t e;
    k = cyc;
    if (d > 0) begin
      ref0 = 1'b1; tick(d); data0 = 1'b1;
    end else if (d < 0) begin
      data0 = 1'b1; tick(-d); ref0 = 1'b1;
    end else begin
      ref0 = 1'b1; data0 = 1'b1;
    end
    e.err  = d[ERR_W-1:0];
    e.slip = 1'b0;
    e.cyc  = k + S + 1 + ((d < 0) ? -d : d);
    q0.push_back(e);
    $display("[TB] dut0 measurement d=%0d queued, expect err=%0d at cycle %0d", d, e.err, e.cyc);
  endtask

  task automatic settle0();
    tick(10);
    ref0 = 1'b0; data0 = 1'b0;
    tick(6);
  endtask

  task automatic reset_dut0();
    reset0 = 1'b1; tick(2);
    reset0 = 1'b0; ref0 = 1'b0; data0 = 1'b0;
    tick(6);
  endtask

  task automatic wait_valid0(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ev0 === 1'b1) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s: err_valid got 0 for 40 cycles, expected 1", name);
    end
  endtask

  task automatic push(input int which, input int ev, input logic sl, input int c);
    exp_t e;
    e.err = ev[ERR_W-1:0]; e.slip = sl; e.cyc = c;
    if (which == 0) q0.push_back(e); else q1.push_back(e);
    $display("[TB] dut%0d expect err=%0d slip=%0d", which, e.err, sl);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int k;
    reset0 = 1'b1; reset1 = 1'b1;
    ref0 = 1'b1; data0 = 1'b1;      // levels held high across reset
    ref1 = 1'b0; data1 = 1'b0;
    tick(3);
    @(negedge clk);
    chk("reset up", up0, 0);
    chk("reset down", down0, 0);
    chk("reset err", err0, 0);
    chk("reset err_valid", ev0, 0);
    chk("reset slip", slip0, 0);
    chk("reset locked", locked0, 0);

    @(posedge clk); #1;
    reset0 = 1'b0; reset1 = 1'b0;
    up_cnt0 = 0; down_cnt0 = 0; ev_cnt0 = 0;
    tick(50);
    chk("static up cycles", up_cnt0, 0);
    chk("static down cycles", down_cnt0, 0);
    chk("static strobes", ev_cnt0, 0);
    chk("static err", err0, 0);
    $display("[TB] static levels after reset checked");
    ref0 = 1'b0; data0 = 1'b0;
    tick(6);

    // ref leads by 5
    up_cnt0 = 0; down_cnt0 = 0;
    edges0(5); settle0();
    chk("lead5 up cycles", up_cnt0, 5);
    chk("lead5 down cycles", down_cnt0, 0);

    // data leads by 3
    up_cnt0 = 0; down_cnt0 = 0;
    edges0(-3); settle0();
    chk("lag3 down cycles", down_cnt0, 3);
    chk("lag3 up cycles", up_cnt0, 0);

    // simultaneous
    up_cnt0 = 0; down_cnt0 = 0;
    edges0(0); settle0();
    chk("same up cycles", up_cnt0, 0);
    chk("same down cycles", down_cnt0, 0);

    // lock acquisition and loss
    reset_dut0();
    for (int i = 0; i < 15; i++) begin
      edges0(lockv[i]); settle0();
    end
    chk("locked after 15", locked0, 0);
    edges0(lockv[15]);
    wait_valid0("lock 16th strobe");
    chk("locked on 16th strobe", locked0, 0);
    @(negedge clk);
    chk("locked after 16th", locked0, 1);
    settle0();
    edges0(3);
    wait_valid0("err +3 strobe");
    chk("locked on +3 strobe", locked0, 1);
    @(negedge clk);
    chk("locked after +3", locked0, 0);
    settle0();

    // cycle slip: ref period 40, data period 80 offset by 10
    reset_dut0();
    for (int t = 0; t < 180; t++) begin
      ref0  = ((t % 40) < 20);
      data0 = (t >= 10) && (((t - 10) % 80) < 40);
      if (t == 10 || t == 90 || t == 170) push(0, 10, 1'b0, -1);
      if (t == 80 || t == 160)            push(0, 127, 1'b1, -1);
      tick(1);
    end
    ref0 = 1'b0; data0 = 1'b0;
    tick(20);
    chk("slip run locked", locked0, 0);

    // counter saturation: data held low for 300 cycles
    reset_dut0();
    ref0 = 1'b1;
    tick(300);
    data0 = 1'b1;
    push(0, 127, 1'b0, -1);
    settle0();

    // bang-bang mode, ref leads by 7
    k = cyc;
    ref1 = 1'b1; tick(7); data1 = 1'b1;
    push(1, 1, 1'b0, k + S + 1 + 7);
    tick(10);
    ref1 = 1'b0; data1 = 1'b0;
    tick(6);

    // reset asserted mid-UP
    ref1 = 1'b1;
    tick(S + 1 + 3);
    @(negedge clk);
    chk("dut1 up before reset", up1, 1);
    reset1 = 1'b1;
    #1;
    chk("dut1 up during reset", up1, 0);
    chk("dut1 err_valid during reset", ev1, 0);
    tick(2);
    reset1 = 1'b0;
    up_cnt1 = 0; down_cnt1 = 0; ev_cnt1 = 0;
    tick(20);
    chk("dut1 up after reset", up_cnt1, 0);
    chk("dut1 strobes after reset", ev_cnt1, 0);
    ref1 = 1'b0;
    tick(3);
    data1 = 1'b1;                   // from IDLE this must open a DOWN interval
    tick(S + 1 + 2);
    @(negedge clk);
    chk("dut1 down after data edge", down1, 1);
    chk("dut1 strobes on data edge", ev_cnt1, 0);
    @(posedge clk); #1;
    ref1 = 1'b1;
    push(1, -1, 1'b0, -1);
    tick(10);
    ref1 = 1'b0; data1 = 1'b0;
    tick(6);

    chk("dut0 queue drained", q0.size(), 0);
    chk("dut1 queue drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    fails++;
    $display("FAIL watchdog: simulation time got 200000 ns, expected completion earlier");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
